tcm_dumper: RTL and testbench
=============================

# tcm_dumper

Hardware readback engine for the tightly-coupled SRAMs. It is the reader counterpart of the file-image loader that fills `gnrl_ram` word arrays. On a start pulse it reads a contiguous range of 32-bit words through the SRAM's synchronous read port. It serialises each word as a byte stream in file order, least-significant byte first, so the emitted stream reproduces the binary image originally loaded. It sits beside `u_srams`, muxed onto the DTCM/ITCM read port, and feeds a byte sink such as a UART TX or a debug FIFO.

## Interface
Parameters:
- `AW`, default 12: word-address width.
- `DEPTH`, default 3500: number of words in the target RAM; addresses wrap at `DEPTH`.

Ports:
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `start`, input, 1: one-cycle request; sampled only in IDLE.
- `base_addr`, input, AW: first word index; latched on accepted `start`.
- `word_cnt`, input, AW+1: number of words to dump; latched on accepted `start`; 0 is legal.
- `ram_cs`, output, 1: SRAM read enable; read data is valid the cycle after `ram_cs`.
- `ram_addr`, output, AW: SRAM word address.
- `ram_rdata`, input, 32: SRAM read data.
- `out_valid`, output, 1: byte available.
- `out_data`, output, 8: byte value.
- `out_ready`, input, 1: sink accepts the byte; a transfer occurs when `out_valid && out_ready`.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle pulse when the dump completes.

## Operation
- States are IDLE, RD, CAP, SEND, FIN.
- IDLE:
  - `start` with `word_cnt!=0`: latch addr and count, go to RD.
  - `start` with `word_cnt==0`: go to FIN.
  - Otherwise stay in IDLE.
- RD: `ram_cs=1`, `ram_addr=addr`. Always go to CAP.
- CAP: `ram_cs=0`. Capture `ram_rdata` into a 32-bit shift register, clear the byte index to 0, go to SEND.
- SEND:
  - `out_valid=1`, `out_data=shreg[7:0]`.
  - On each transfer: shift the register right by 8 and increment the byte index.
  - On the transfer of byte index 3:
    - Decrement the count.
    - Advance addr: `addr==DEPTH-1` wraps to 0, otherwise `addr+1`.
    - Go to RD if the remaining count is nonzero, else go to FIN.
- FIN: `done=1` for exactly one cycle, then go to IDLE.
- Byte order per word is `rdata[7:0]`, `[15:8]`, `[23:16]`, `[31:24]`. This is the inverse of the loader's byte swap.
- `start` asserted while `busy=1` is ignored and has no side effects.
- Outputs are registered or decoded only from state. No combinational path exists from `out_ready` to `out_valid`/`out_data`.
- Count arithmetic is AW+1 bits and never underflows, because FIN is entered at count 0.

## Timing
- Reset values: `ram_cs=0`, `ram_addr=0`, `out_valid=0`, `out_data=0`, `busy=0`, `done=0`; state IDLE; the internal addr, count and shift register are 0.
- Reset asserted mid-dump aborts immediately to the reset values. No `done` is produced, and no byte is emitted after `rst_n` falls.
- Take `start` sampled at edge T0 with `word_cnt>=1`:
  - `ram_cs` is high in cycle T0+1.
  - The first `out_valid` is high in cycle T0+3.
- With `out_ready` held high, each word costs 6 cycles (RD, CAP, 4×SEND). An N-word dump ends with `done` in the cycle after the final transfer, 6N+1 cycles after `start`.
- `word_cnt==0`: `done` is high in cycle T0+1, with no `ram_cs` and no `out_valid`.
- Backpressure: while `out_valid && !out_ready`, `out_data` is held stable. `out_valid` never drops until the transfer occurs.
- `busy` rises in the cycle after an accepted `start` and falls in the cycle after FIN. `done` and `busy` are both high in the FIN cycle.

## Test plan
- Single word, no backpressure:
  - Stimulus: mem[0]=0x44332211, `base_addr=0`, `word_cnt=1`, `out_ready=1`.
  - Required response: `ram_cs` for one cycle with addr 0; bytes 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles starting T0+3; `done` at T0+7.
- Backpressure:
  - Stimulus: mem[5]=0xDEADBEEF, `word_cnt=1`, `base_addr=5`; `out_ready` toggled 1,0,0,1,…
  - Required response: bytes 0xEF, 0xBE, 0xAD, 0xDE; `out_data` stable during stalls; exactly 4 transfers, then `done`.
- Wrap-around:
  - Stimulus: `base_addr=DEPTH-1`, `word_cnt=2`, mem[3499]=0x0000_0001, mem[0]=0x0000_0013.
  - Required response: reads at addr 3499 then 0; stream 01,00,00,00,13,00,00,00.
- Zero count and ignored restart:
  - `word_cnt=0` → `done` one cycle after `start`, no RAM access.
  - A `start` pulse mid-dump → no change to addr, count or stream.
- Reset mid-operation:
  - Stimulus: a 3-word dump; drop `rst_n` during the second word's SEND.
  - Required response: all outputs return to 0 asynchronously and no `done` is produced. A fresh `start` after release dumps from its new `base_addr` correctly.
- Full image compare:
  - Stimulus: load a 64-word image, dump it with random `out_ready`.
  - Required response: the collected byte stream equals the original file bytes exactly.

Source files
------------

// File: rtl/tcm_dumper_if.sv
// Control, SRAM read port and byte-stream handshake of the TCM readback engine.
// The dumper takes the master side; the surrounding system takes the slave side.
interface tcm_dumper_if #(
  parameter int AW = 12
) ();
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   word_cnt;
  logic          ram_cs;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_rdata;
  logic          out_valid;
  logic [7:0]    out_data;
  logic          out_ready;
  logic          busy;
  logic          done;

  modport master (
    input  start, base_addr, word_cnt, ram_rdata, out_ready,
    output ram_cs, ram_addr, out_valid, out_data, busy, done
  );

  modport slave (
    output start, base_addr, word_cnt, ram_rdata, out_ready,
    input  ram_cs, ram_addr, out_valid, out_data, busy, done
  );
endinterface

// File: rtl/tcm_dumper.sv
// Reads a contiguous word range from a TCM through its synchronous read port and
// streams each word out as bytes, least-significant first (file order).
module tcm_dumper #(
  parameter int AW    = 12,
  parameter int DEPTH = 3500
) (
  input logic         clk,
  input logic         rst_n,
  tcm_dumper_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_SEND,
    S_FIN
  } state_e;

  localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [31:0]   shreg_q, shreg_d;
  logic [1:0]    idx_q, idx_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      shreg_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.word_cnt != '0) begin
            addr_d  = bus.base_addr;
            cnt_d   = bus.word_cnt;
            state_d = S_RD;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_RD: state_d = S_CAP;
      S_CAP: begin
        shreg_d = bus.ram_rdata;
        idx_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (bus.out_ready) begin
          shreg_d = {8'h00, shreg_q[31:8]};
          idx_d   = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            // FIN is entered at count zero, so the decrement can never wrap
            cnt_d   = cnt_q - CNT_ONE;
            addr_d  = (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_ONE;
            state_d = (cnt_d != '0) ? S_RD : S_FIN;
          end
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Every output comes from a flop, so out_ready never reaches out_valid/out_data
  assign bus.ram_cs    = (state_q == S_RD);
  assign bus.ram_addr  = addr_q;
  assign bus.out_valid = (state_q == S_SEND);
  assign bus.out_data  = shreg_q[7:0];
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_FIN);
endmodule

// File: tb/tb_tcm_dumper.sv
// Directed and randomized checks of tcm_dumper against a queue-based model of
// the expected read addresses and byte stream.
module tb_tcm_dumper;
  localparam int AW    = 12;
  localparam int DEPTH = 3500;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tcm_dumper_if #(.AW(AW)) bus ();

  tcm_dumper #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;
  always @(posedge clk) if (bus.ram_cs) rdata_q <= mem[bus.ram_addr];
  assign bus.ram_rdata = rdata_q;

  int vectors = 0;
  int miscompares = 0;
  int exp_addr[$];
  logic [7:0] exp_byte[$];
  logic [7:0] got[$];
  logic [7:0] img[256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // rmode: 0 = always ready, 1 = ready pattern 1,0,0 repeating, 2 = random ready
  task automatic do_dump(input int base, input int cnt, input int rmode,
                         input int inj_cyc, input string tag);
    int cyc, first_v, done_cyc, reads, xfers, budget;
    logic r, stall, fin;
    logic [7:0] held;
    exp_addr.delete(); exp_byte.delete(); got.delete();
    for (int w = 0; w < cnt; w++) begin
      int a;
      a = (base + w) % DEPTH;
      exp_addr.push_back(a);
      for (int b = 0; b < 4; b++) exp_byte.push_back(mem[a][8*b +: 8]);
    end
    @(negedge clk);
    bus.base_addr = AW'(base);
    bus.word_cnt  = (AW + 1)'(cnt);
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.base_addr = AW'($urandom_range(0, DEPTH - 1));
    bus.word_cnt  = (AW + 1)'($urandom_range(1, 7));
    cyc = 0; first_v = -1; done_cyc = -1; reads = 0; xfers = 0;
    stall = 1'b0; fin = 1'b0; held = '0; budget = 40 * cnt + 20;
    while (!fin && cyc < budget) begin
      @(negedge clk);
      cyc++;
      case (rmode)
        0: r = 1'b1;
        1: r = ((cyc % 3) == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      bus.out_ready = r;
      if (cyc == inj_cyc) begin
        bus.start     = 1'b1;
        bus.base_addr = AW'($urandom_range(0, DEPTH - 1));
        bus.word_cnt  = (AW + 1)'($urandom_range(1, 9));
      end else begin
        bus.start = 1'b0;
      end
      chk($sformatf("%s busy c%0d", tag, cyc), 32'(bus.busy), 32'd1);
      if (bus.ram_cs) begin
        reads++;
        if (exp_addr.size() != 0)
          chk($sformatf("%s addr r%0d", tag, reads), 32'(bus.ram_addr), 32'(exp_addr.pop_front()));
      end
      if (stall) begin
        chk($sformatf("%s stall valid c%0d", tag, cyc), 32'(bus.out_valid), 32'd1);
        chk($sformatf("%s stall data c%0d", tag, cyc), 32'(bus.out_data), 32'(held));
      end
      if (bus.out_valid && first_v < 0) first_v = cyc;
      if (bus.out_valid && r) begin
        xfers++;
        got.push_back(bus.out_data);
        if (exp_byte.size() != 0)
          chk($sformatf("%s byte %0d", tag, xfers - 1), 32'(bus.out_data), 32'(exp_byte.pop_front()));
      end
      stall = bus.out_valid && !r;
      held  = bus.out_data;
      if (bus.done) begin
        done_cyc = cyc;
        fin = 1'b1;
      end
    end
    bus.start = 1'b0;
    if (!fin) chk({tag, " done timeout"}, 32'(bus.done), 32'd1);
    chk({tag, " transfers"}, 32'(xfers), 32'(4 * cnt));
    chk({tag, " reads"}, 32'(reads), 32'(cnt));
    if (rmode == 0) begin
      chk({tag, " done cycle"}, 32'(done_cyc), 32'(6 * cnt + 1));
      chk({tag, " first valid"}, 32'(first_v), (cnt > 0) ? 32'd3 : 32'hFFFF_FFFF);
    end
    @(negedge clk);
    chk({tag, " busy after"}, 32'(bus.busy), 32'd0);
    chk({tag, " done pulse"}, 32'(bus.done), 32'd0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, " ram_cs"}, 32'(bus.ram_cs), 32'd0);
    chk({tag, " ram_addr"}, 32'(bus.ram_addr), 32'd0);
    chk({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, " out_data"}, 32'(bus.out_data), 32'd0);
    chk({tag, " busy"}, 32'(bus.busy), 32'd0);
    chk({tag, " done"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int base;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.word_cnt = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    mem[0] = 32'h4433_2211;
    do_dump(0, 1, 0, 0, "single");

    mem[5] = 32'hDEAD_BEEF;
    do_dump(5, 1, 1, 0, "backpressure");

    mem[DEPTH-1] = 32'h0000_0001;
    mem[0]       = 32'h0000_0013;
    do_dump(DEPTH - 1, 2, 0, 0, "wrap");

    do_dump(77, 0, 0, 0, "zero");
    do_dump(300, 3, 2, 8, "restart_ignored");
    do_dump(1000, 4, 0, 9, "restart_fixed");

    // Abort during the second word's SEND phase
    @(negedge clk);
    bus.base_addr = AW'(100);
    bus.word_cnt  = (AW + 1)'(3);
    bus.start     = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid word2 valid", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_zero_outputs("async reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset no done", 32'(bus.done), 32'd0);
      chk("reset no valid", 32'(bus.out_valid), 32'd0);
    end
    rst_n = 1'b1;
    do_dump(200, 2, 0, 0, "after_reset");

    base = $urandom_range(0, DEPTH - 1);
    for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
    for (int w = 0; w < 64; w++)
      mem[(base + w) % DEPTH] = {img[4*w+3], img[4*w+2], img[4*w+1], img[4*w]};
    do_dump(base, 64, 2, 0, "image");
    chk("image length", 32'(got.size()), 32'd256);
    for (int i = 0; i < 256 && i < got.size(); i++)
      chk($sformatf("image byte %0d", i), 32'(got[i]), 32'(img[i]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
